// File: rtl/eth_port_regs_pkg.sv
// Shared definitions for the IPv4/UDP port register block.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
//
// Contents: register map offsets and strides, INFO compat constant,
// address slot record, KV commit FSM states, decoded-address record.
package eth_port_regs_pkg;

  // Byte offsets of the register map
  localparam logic [31:0] ADDR_INFO       = 32'h000;
  localparam logic [31:0] ADDR_ACTIVE_SEL = 32'h004;
  localparam logic [31:0] SLOT_BASE       = 32'h100;
  localparam logic [31:0] CNT_BASE        = 32'h200;
  localparam logic [31:0] KV_BASE         = 32'h300;
  localparam logic [31:0] KV_CFG          = 32'h310;

  localparam int SLOT_STRIDE = 16;
  localparam int CNT_STRIDE  = 4;
  localparam int KV_SPAN     = 16;

  // Low half of INFO identifies the register-set generation
  localparam logic [15:0] INFO_COMPAT = 16'h0100;

  typedef struct packed {
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] udp;
  } addr_slot_t;

  typedef enum logic {
    KV_IDLE,
    KV_PEND
  } kv_state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_INFO,
    SEL_ACTIVE,
    SEL_SLOT,
    SEL_CNT,
    SEL_KV,
    SEL_KV_CFG
  } reg_sel_t;

  // Result of decoding one byte address: target, window index, word within window
  typedef struct packed {
    reg_sel_t   sel;
    logic [4:0] idx;
    logic [1:0] sub;
  } reg_dec_t;

  function automatic logic [31:0] info_word(input int num_addr, input int num_cnt);
    return {8'(num_cnt), 8'(num_addr), INFO_COMPAT};
  endfunction

endpackage

// File: rtl/eth_evt_counter.sv
// Saturating event counter with clear-on-read.
// Latency: count reflects evt/clr on the next bus_clk edge.
// Backpressure: none; an event coinciding with a clear is kept (count becomes 1).
//
// Ports: bus_clk, bus_rst_n (sync, active-low), evt (one-cycle pulse),
//        clr (read strobe for this counter), count (current value).
module eth_evt_counter #(
  parameter int CNT_W = 32
) (
  input  logic             bus_clk,
  input  logic             bus_rst_n,
  input  logic             evt,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      count <= '0;
    end else if (clr) begin
      // The reader already took the old value; a simultaneous event starts the new epoch
      count <= evt ? CNT_W'(1) : '0;
    end else if (evt && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/eth_ipv4_port_regs.sv
// Register block for one IPv4/UDP port: address slots, event counters, KV commit strobe.
// Latency: reads answer 1 cycle after reg_rd_req; slot/select writes reach my_* 2 cycles after reg_wr_req.
// Backpressure: kv_busy holds a KV commit in PEND; further CFG writes there merge and flag overflow.
//
// Build option: ETH_PORT_REGS_KV_EN adds the KV registers (0x300-0x310) and commit FSM;
// without it that range is unmapped, kv_* outputs are 0 and kv_busy is ignored.
// Ports: bus_clk/bus_rst_n; reg_wr_*/reg_rd_* register port; cnt_evt event pulses;
//        my_* active-slot address; kv_stb/kv_busy/kv_* key-value commit interface.
module eth_ipv4_port_regs
  import eth_port_regs_pkg::*;
#(
  parameter int           NUM_ADDR    = 2,
  parameter int           NUM_CNT     = 4,
  parameter int           CNT_W       = 32,
  parameter int           REG_AWIDTH  = 14,
  parameter logic [47:0]  DEFAULT_MAC = 48'h00802f16c52f,
  parameter logic [31:0]  DEFAULT_IP  = 32'hC0A80A02,
  parameter logic [15:0]  DEFAULT_UDP = 16'd49153
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic                  reg_wr_req,
  input  logic [REG_AWIDTH-1:0] reg_wr_addr,
  input  logic [31:0]           reg_wr_data,
  input  logic                  reg_rd_req,
  input  logic [REG_AWIDTH-1:0] reg_rd_addr,
  output logic                  reg_rd_resp,
  output logic [31:0]           reg_rd_data,
  input  logic [NUM_CNT-1:0]    cnt_evt,
  output logic [47:0]           my_mac,
  output logic [31:0]           my_ip,
  output logic [15:0]           my_udp_port,
  output logic                  kv_stb,
  input  logic                  kv_busy,
  output logic [47:0]           kv_mac_addr,
  output logic [31:0]           kv_ip_addr,
  output logic [15:0]           kv_udp_port,
  output logic [15:0]           kv_dst_epid,
  output logic                  kv_raw_udp
);

  localparam addr_slot_t DEF_SLOT = '{mac: DEFAULT_MAC, ip: DEFAULT_IP, udp: DEFAULT_UDP};

  // Full-address decode; anything outside a populated window is SEL_NONE
  function automatic reg_dec_t decode(input logic [REG_AWIDTH-1:0] a);
    reg_dec_t    d;
    logic [31:0] ax;
    logic [31:0] off;
    ax  = 32'(a);
    d   = '{sel: SEL_NONE, idx: '0, sub: '0};
    off = '0;
    if (ax == ADDR_INFO) begin
      d.sel = SEL_INFO;
    end else if (ax == ADDR_ACTIVE_SEL) begin
      d.sel = SEL_ACTIVE;
    end else if (ax[1:0] == 2'b00) begin
      if (ax >= SLOT_BASE && (ax - SLOT_BASE) < 32'(NUM_ADDR * SLOT_STRIDE)) begin
        off   = ax - SLOT_BASE;
        d.sel = SEL_SLOT;
        d.idx = 5'(off / 32'(SLOT_STRIDE));
        d.sub = off[3:2];
      end else if (ax >= CNT_BASE && (ax - CNT_BASE) < 32'(NUM_CNT * CNT_STRIDE)) begin
        off   = ax - CNT_BASE;
        d.sel = SEL_CNT;
        d.idx = 5'(off / 32'(CNT_STRIDE));
`ifdef ETH_PORT_REGS_KV_EN
      end else if (ax >= KV_BASE && (ax - KV_BASE) < 32'(KV_SPAN)) begin
        off   = ax - KV_BASE;
        d.sel = SEL_KV;
        d.sub = off[3:2];
      end else if (ax == KV_CFG) begin
        d.sel = SEL_KV_CFG;
`endif
      end
    end
    return d;
  endfunction

  reg_dec_t wr_dec, rd_dec;

  always_comb begin
    wr_dec = decode(reg_wr_addr);
    rd_dec = decode(reg_rd_addr);
  end

  // ---------------------------------------------------------------- address slots
  addr_slot_t slot [NUM_ADDR];
  logic [3:0] active_sel;
  addr_slot_t act_slot;

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      for (int i = 0; i < NUM_ADDR; i++) slot[i] <= DEF_SLOT;
      active_sel <= '0;
    end else if (reg_wr_req) begin
      if (wr_dec.sel == SEL_ACTIVE && reg_wr_data < 32'(NUM_ADDR))
        active_sel <= reg_wr_data[3:0];
      if (wr_dec.sel == SEL_SLOT) begin
        for (int i = 0; i < NUM_ADDR; i++) begin
          if (wr_dec.idx == 5'(i)) begin
            case (wr_dec.sub)
              2'd0:    slot[i].mac[31:0]  <= reg_wr_data;
              2'd1:    slot[i].mac[47:32] <= reg_wr_data[15:0];
              2'd2:    slot[i].ip         <= reg_wr_data;
              default: slot[i].udp        <= reg_wr_data[15:0];
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    act_slot = DEF_SLOT;
    for (int i = 0; i < NUM_ADDR; i++)
      if (active_sel == 4'(i)) act_slot = slot[i];
  end

  // Second register stage gives the fixed 2-cycle write-to-my_* latency
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      my_mac      <= DEFAULT_MAC;
      my_ip       <= DEFAULT_IP;
      my_udp_port <= DEFAULT_UDP;
    end else begin
      my_mac      <= act_slot.mac;
      my_ip       <= act_slot.ip;
      my_udp_port <= act_slot.udp;
    end
  end

  // ---------------------------------------------------------------- event counters
  logic [CNT_W-1:0] cnt_val [NUM_CNT];
  logic [31:0]      cnt_ext [NUM_CNT];

  for (genvar j = 0; j < NUM_CNT; j++) begin : g_cnt
    logic cnt_clr;
    assign cnt_clr    = reg_rd_req && (rd_dec.sel == SEL_CNT) && (rd_dec.idx == 5'(j));
    assign cnt_ext[j] = 32'(cnt_val[j]);

    eth_evt_counter #(.CNT_W(CNT_W)) u_cnt (
      .bus_clk   (bus_clk),
      .bus_rst_n (bus_rst_n),
      .evt       (cnt_evt[j]),
      .clr       (cnt_clr),
      .count     (cnt_val[j])
    );
  end

  // ---------------------------------------------------------------- KV commit
`ifdef ETH_PORT_REGS_KV_EN
  kv_state_t   kv_state;
  logic        kv_ovf;
  logic [47:0] kv_mac_stg;
  logic [31:0] kv_ip_stg;
  logic [15:0] kv_udp_stg;
  logic        kv_stb_q;
  logic [47:0] kv_mac_q;
  logic [31:0] kv_ip_q;
  logic [15:0] kv_udp_q;
  logic [15:0] kv_epid_q;
  logic        kv_raw_q;
  logic        kv_cfg_wr;
  logic        kv_cfg_rd;

  assign kv_cfg_wr = reg_wr_req && (wr_dec.sel == SEL_KV_CFG);
  assign kv_cfg_rd = reg_rd_req && (rd_dec.sel == SEL_KV_CFG);

  // Staging registers are snapshotted into kv_* only on a CFG write,
  // so the consumer sees a stable entry from kv_stb until the next CFG write.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      kv_state   <= KV_IDLE;
      kv_ovf     <= 1'b0;
      kv_stb_q   <= 1'b0;
      kv_mac_stg <= '0;
      kv_ip_stg  <= '0;
      kv_udp_stg <= '0;
      kv_mac_q   <= '0;
      kv_ip_q    <= '0;
      kv_udp_q   <= '0;
      kv_epid_q  <= '0;
      kv_raw_q   <= 1'b0;
    end else begin
      kv_stb_q <= 1'b0;
      if (reg_wr_req && wr_dec.sel == SEL_KV) begin
        case (wr_dec.sub)
          2'd0:    kv_mac_stg[31:0]  <= reg_wr_data;
          2'd1:    kv_mac_stg[47:32] <= reg_wr_data[15:0];
          2'd2:    kv_ip_stg         <= reg_wr_data;
          default: kv_udp_stg        <= reg_wr_data[15:0];
        endcase
      end
      if (kv_cfg_wr) begin
        kv_mac_q  <= kv_mac_stg;
        kv_ip_q   <= kv_ip_stg;
        kv_udp_q  <= kv_udp_stg;
        kv_epid_q <= reg_wr_data[15:0];
        kv_raw_q  <= reg_wr_data[16];
      end
      // Clear first so a merge in the same cycle still leaves overflow set
      if (kv_cfg_rd) kv_ovf <= 1'b0;
      case (kv_state)
        KV_IDLE: begin
          if (kv_cfg_wr) begin
            if (kv_busy) kv_state <= KV_PEND;
            else         kv_stb_q <= 1'b1;
          end
        end
        default: begin
          if (kv_cfg_wr) kv_ovf <= 1'b1;
          if (!kv_busy) begin
            kv_stb_q <= 1'b1;
            kv_state <= KV_IDLE;
          end
        end
      endcase
    end
  end

  assign kv_stb      = kv_stb_q;
  assign kv_mac_addr = kv_mac_q;
  assign kv_ip_addr  = kv_ip_q;
  assign kv_udp_port = kv_udp_q;
  assign kv_dst_epid = kv_epid_q;
  assign kv_raw_udp  = kv_raw_q;
`else
  logic unused_kv_busy;
  assign unused_kv_busy = kv_busy;
  assign kv_stb      = 1'b0;
  assign kv_mac_addr = '0;
  assign kv_ip_addr  = '0;
  assign kv_udp_port = '0;
  assign kv_dst_epid = '0;
  assign kv_raw_udp  = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic        rd_hit;
  logic [31:0] rd_val;

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (rd_dec.sel)
      SEL_INFO:   rd_val = info_word(NUM_ADDR, NUM_CNT);
      SEL_ACTIVE: rd_val = {28'h0, active_sel};
      SEL_SLOT: begin
        for (int i = 0; i < NUM_ADDR; i++) begin
          if (rd_dec.idx == 5'(i)) begin
            case (rd_dec.sub)
              2'd0:    rd_val = slot[i].mac[31:0];
              2'd1:    rd_val = {16'h0, slot[i].mac[47:32]};
              2'd2:    rd_val = slot[i].ip;
              default: rd_val = {16'h0, slot[i].udp};
            endcase
          end
        end
      end
      SEL_CNT: begin
        for (int j = 0; j < NUM_CNT; j++)
          if (rd_dec.idx == 5'(j)) rd_val = cnt_ext[j];
      end
`ifdef ETH_PORT_REGS_KV_EN
      SEL_KV: begin
        case (rd_dec.sub)
          2'd0:    rd_val = kv_mac_stg[31:0];
          2'd1:    rd_val = {16'h0, kv_mac_stg[47:32]};
          2'd2:    rd_val = kv_ip_stg;
          default: rd_val = {16'h0, kv_udp_stg};
        endcase
      end
      SEL_KV_CFG: rd_val = {(kv_state == KV_PEND), kv_ovf, 30'h0};
`endif
      default: rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (!bus_rst_n) begin
      reg_rd_resp <= 1'b0;
      reg_rd_data <= '0;
    end else begin
      reg_rd_resp <= reg_rd_req && rd_hit;
      reg_rd_data <= (reg_rd_req && rd_hit) ? rd_val : '0;
    end
  end

endmodule
